keypad_digit_loader: RTL and testbench
======================================

# keypad_digit_loader

Consumer end of the keypad priority encoder: takes its `bcd_output`/`valid` pair and captures each new key press as a BCD digit. Digits shift into a 4-digit MM:SS time-entry register for the microwave controller. The register is also decoded onto a time-multiplexed, active-low 4-digit seven-segment display. The block sits between the keypad encoder and the cook-timer/display logic.

## Interface
- `SCAN_DIV`, default 4: clock cycles each display digit stays selected; legal range ≥ 1.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `bcd_in`  in  4  digit from the keypad encoder.
- `valid`  in  1  high while exactly one key is pressed; level, not pulse.
- `load_en`  in  1  high = key entry allowed; low while cooking.
- `clear`  in  1  synchronous clear of the entered time.
- `digits`  out  16  {min_tens, min_units, sec_tens, sec_units}; `[3:0]` is the newest digit.
- `count`  out  3  number of digits entered, 0..4.
- `key_strobe`  out  1  one-cycle pulse for each accepted digit.
- `an_n`  out  4  active-low digit select; `an_n[0]` = sec_units.
- `seg_n`  out  7  active-low segments; `seg_n[0]` = a … `seg_n[6]` = g.

## Operation
- `valid_d` is a registered copy of `valid`, updated every cycle, including during `clear` and while `load_en` = 0.
- Edge: `valid` = 1 and `valid_d` = 0.
- Accept: edge and `load_en` = 1 and `bcd_in` ≤ 9 and `count` < 4 and `clear` = 0.
- On accept:
  - `digits` <= {`digits[11:0]`, `bcd_in`}.
  - `count` <= `count` + 1.
  - `key_strobe` <= 1.
- Otherwise `key_strobe` <= 0.
- Held key: a level held for any number of cycles gives exactly one accept.
- Edge while `load_en` = 0:
  - The edge is consumed.
  - Raising `load_en` while the key is still held does not produce an accept.
- Edge with `bcd_in` > 9: rejected; no state change except `valid_d`.
- `count` = 4: further edges are ignored and `digits` is frozen (saturation, no wrap).
- `clear` = 1:
  - `digits` <= 0 and `count` <= 0.
  - `clear` has priority over a simultaneous accept; that key is lost.
- Display scan:
  - Prescaler `pre` counts 0..`SCAN_DIV`-1.
  - When `pre` = `SCAN_DIV`-1, `pre` <= 0 and index `idx` <= `idx` + 1 mod 4 (wraps 3→0).
- Display outputs, registered every cycle:
  - `an_n` <= one-cold(`idx`): `idx` 0 → 4'b1110, 1 → 1101, 2 → 1011, 3 → 0111.
  - `seg_n` <= dec(`digits[4·idx+3 : 4·idx]`).
- Decode table (gfedcba, active low):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001.
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000.
  - Any value > 9 = 1111111 (blank); cannot occur in normal operation.
- No leading-zero blanking.

## Timing
- Reset values (`rst` sampled high at an edge):
  - `digits` = 16'h0000, `count` = 0, `key_strobe` = 0.
  - `valid_d` = 0, `pre` = 0, `idx` = 0.
  - `an_n` = 4'b1110, `seg_n` = 7'b1000000.
- `rst` overrides `clear` and accept.
- Reset mid-entry discards all entered digits.
- A key held across reset release is seen as an edge on the first post-reset cycle, because `valid_d` resets to 0.
- Input-to-output latency:
  - `valid` rising is sampled at edge k.
  - `digits`, `count` and `key_strobe` change after edge k.
  - `key_strobe` is high for exactly one cycle, from edge k to edge k+1.
- Display latency:
  - `an_n`/`seg_n` lag `idx` and `digits` by one cycle.
  - Each digit is shown for exactly `SCAN_DIV` cycles.
  - One full frame is 4·`SCAN_DIV` cycles.
- `SCAN_DIV` = 1: `idx` advances every cycle.
- The display scan runs continuously; it is unaffected by `clear`, `load_en` and key activity.
- All outputs are registered; no combinational input-to-output path.

## Test plan
- Reset then key sequence 1, 2, 3, 0, each held 3 cycles with 2 idle cycles between → `digits` = 16'h1230, `count` = 4, exactly 4 `key_strobe` pulses, each one cycle wide and one cycle after the corresponding rising edge.
- With `count` = 4, press 7 → no strobe, `digits` stays 16'h1230. Then `clear` for 1 cycle → `digits` = 0, `count` = 0. Then press 5 → `digits` = 16'h0005.
- Press 9 with `load_en` = 0, raise `load_en` while key held, release, press 4 → only 4 accepted, `digits` = 16'h0004.
- `clear` asserted in the same cycle as the rising edge of key 8 → `digits` = 0, `count` = 0, no strobe. `bcd_in` = 4'hA with a `valid` edge → rejected.
- `SCAN_DIV` = 4, `digits` = 16'h1230 → `an_n` cycles 1110, 1101, 1011, 0111 with 4 cycles each, and `seg_n` = 1000000, 0110000, 0100100, 1111001 respectively. Repeat with `SCAN_DIV` = 1.
- Enter 6, 2, assert `rst` for 1 cycle while key 3 is held → all reset values. First cycle after reset: 3 accepted, `digits` = 16'h0003, `count` = 1.

Source files
------------

// File: rtl/keypad_digit_loader.sv
// keypad_digit_loader
// Captures debounced key presses from the keypad priority encoder as BCD
// digits, shifts them into a 4-digit MM:SS entry register, and scans that
// register onto an active-low, time-multiplexed 4-digit seven-segment display.
module keypad_digit_loader #(
  parameter int SCAN_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  bcd_in,
  input  logic        valid,
  input  logic        load_en,
  input  logic        clear,
  output logic [15:0] digits,
  output logic [2:0]  count,
  output logic        key_strobe,
  output logic [3:0]  an_n,
  output logic [6:0]  seg_n
);

  // Prescaler is at least one bit wide so SCAN_DIV = 1 still elaborates;
  // in that case it sits at 0 and the digit index advances every cycle.
  localparam int             PRE_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(SCAN_DIV - 1);

  logic             valid_d;
  logic             accept;
  logic [PRE_W-1:0] pre;
  logic [1:0]       idx;
  logic [3:0]       cur_digit;
  logic [3:0]       an_next;
  logic [6:0]       seg_next;

  // Active-low gfedcba pattern for one BCD digit; non-BCD codes blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  // A key is taken only on the rising edge of valid, so a held key yields a
  // single digit and an edge seen while entry is disabled is simply lost.
  always_comb begin
    accept = valid && !valid_d && load_en && (bcd_in <= 4'd9) &&
             (count < 3'd4) && !clear;
  end

  // Entry register, digit counter, strobe and the valid edge detector.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling the
    // pre-edge values, so the shift and the edge detector cannot race.
    if (rst) begin
      valid_d    <= 1'b0;
      digits     <= 16'h0000;
      count      <= 3'd0;
      key_strobe <= 1'b0;
    end else begin
      valid_d    <= valid;
      key_strobe <= accept;
      if (clear) begin
        digits <= 16'h0000;
        count  <= 3'd0;
      end else if (accept) begin
        digits <= {digits[11:0], bcd_in};
        count  <= count + 3'd1;
      end
    end
  end

  // Free-running display scan: hold each digit for SCAN_DIV cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre <= '0;
      idx <= 2'd0;
    end else if (pre == PRE_MAX) begin
      pre <= '0;
      idx <= idx + 2'd1;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  // Select the nibble under the scan index and form the next drive pattern.
  always_comb begin
    // NOTE: every output of this block gets a value before any branch, so no
    // path can leave one unassigned and infer a latch.
    cur_digit = 4'd0;
    an_next   = 4'b1111;
    seg_next  = 7'b1111111;
    cur_digit = digits[{idx, 2'b00} +: 4];
    an_next   = ~(4'b0001 << idx);
    seg_next  = seg_decode(cur_digit);
  end

  // Registered display drive, one cycle behind idx and digits.
  always_ff @(posedge clk) begin
    if (rst) begin
      an_n  <= 4'b1110;
      seg_n <= 7'b1000000;
    end else begin
      an_n  <= an_next;
      seg_n <= seg_next;
    end
  end

endmodule

// File: tb/tb_keypad_digit_loader.sv
// Self-checking bench for keypad_digit_loader: a scoreboard of expected
// entry-register contents is pushed on each press and popped on each strobe;
// two instances cover the SCAN_DIV = 4 and SCAN_DIV = 1 display scans.
module tb_keypad_digit_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  bcd_in = 4'd0;
  logic        valid = 1'b0;
  logic        load_en = 1'b1;
  logic        clear = 1'b0;

  logic [15:0] digits4, digits1;
  logic [2:0]  count4, count1;
  logic        strobe4, strobe1;
  logic [3:0]  an4, an1;
  logic [6:0]  seg4, seg1;

  typedef struct {
    logic [15:0] d;
    logic [2:0]  c;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          strobes_seen = 0;
  int          pushes = 0;
  logic [15:0] m_digits = 16'h0;
  logic [2:0]  m_count = 3'd0;

  keypad_digit_loader #(.SCAN_DIV(4)) u4 (
    .clk(clk), .rst(rst), .bcd_in(bcd_in), .valid(valid), .load_en(load_en),
    .clear(clear), .digits(digits4), .count(count4), .key_strobe(strobe4),
    .an_n(an4), .seg_n(seg4)
  );

  keypad_digit_loader #(.SCAN_DIV(1)) u1 (
    .clk(clk), .rst(rst), .bcd_in(bcd_in), .valid(valid), .load_en(load_en),
    .clear(clear), .digits(digits1), .count(count1), .key_strobe(strobe1),
    .an_n(an1), .seg_n(seg1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: every strobe must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && strobe4) begin
      strobes_seen++;
      if (sb.size() == 0) begin
        check("unexpected_strobe", 16'd1, 16'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_digits", digits4, e.d);
        check("sb_count", {13'd0, count4}, {13'd0, e.c});
      end
    end
  end

  // One key press: held 3 cycles, then 2 idle cycles.
  task automatic press(input logic [3:0] k, input bit with_clear);
    bit acc;
    acc = load_en && (k <= 4'd9) && (m_count < 3'd4) && !with_clear;
    if (acc) begin
      m_digits = {m_digits[11:0], k};
      m_count  = m_count + 3'd1;
      sb.push_back('{d: m_digits, c: m_count});
      pushes++;
    end else if (with_clear) begin
      m_digits = 16'h0;
      m_count  = 3'd0;
    end
    bcd_in = k;
    valid  = 1'b1;
    clear  = with_clear;
    step();
    clear = 1'b0;
    check("strobe_after_edge", {15'd0, strobe4}, {15'd0, acc});
    step();
    check("strobe_width", {15'd0, strobe4}, 16'd0);
    step();
    valid = 1'b0;
    step();
    step();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    m_digits = 16'h0;
    m_count  = 3'd0;
    check("clear_digits", digits4, 16'h0);
    check("clear_count", {13'd0, count4}, 16'd0);
  endtask

  // Lock onto the start of a frame, then check one whole frame of the scan.
  task automatic scan_check(input int div, input bit fast);
    logic [3:0] exp_an[4];
    logic [6:0] exp_seg[4];
    logic [3:0] prev;
    bit         found;
    exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    exp_seg = '{7'b1000000, 7'b0110000, 7'b0100100, 7'b1111001};
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      prev = fast ? an1 : an4;
      step();
      if ((fast ? an1 : an4) == 4'b1110 && prev != 4'b1110) found = 1'b1;
    end
    check("scan_frame_start", {15'd0, found}, 16'd1);
    if (found) begin
      for (int d = 0; d < 4; d++) begin
        for (int c = 0; c < div; c++) begin
          check(fast ? "an_div1" : "an_div4", {12'd0, fast ? an1 : an4},
                {12'd0, exp_an[d]});
          check(fast ? "seg_div1" : "seg_div4", {9'd0, fast ? seg1 : seg4},
                {9'd0, exp_seg[d]});
          step();
        end
      end
      // The frame must restart on digit 0 after exactly 4*div cycles.
      check(fast ? "an_wrap_div1" : "an_wrap_div4", {12'd0, fast ? an1 : an4},
            16'h000e);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_digits"}, digits4, 16'h0);
    check({tag, "_count"}, {13'd0, count4}, 16'd0);
    check({tag, "_strobe"}, {15'd0, strobe4}, 16'd0);
    check({tag, "_an"}, {12'd0, an4}, 16'h000e);
    check({tag, "_seg"}, {9'd0, seg4}, {9'd0, 7'b1000000});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    rst = 1'b1;
    step();
    step();
    check_reset_state("reset");
    rst = 1'b0;

    // Key sequence 1, 2, 3, 0.
    press(4'd1, 1'b0);
    press(4'd2, 1'b0);
    press(4'd3, 1'b0);
    press(4'd0, 1'b0);
    check("seq_digits", digits4, 16'h1230);
    check("seq_count", {13'd0, count4}, 16'd4);
    check("seq_strobes", strobes_seen[15:0], 16'd4);

    // Saturation, clear, re-entry.
    press(4'd7, 1'b0);
    check("sat_digits", digits4, 16'h1230);
    check("sat_count", {13'd0, count4}, 16'd4);
    do_clear();
    press(4'd5, 1'b0);
    check("after_clear_digits", digits4, 16'h0005);

    // Edge while entry disabled is consumed; later raising load_en is no edge.
    do_clear();
    load_en = 1'b0;
    bcd_in  = 4'd9;
    valid   = 1'b1;
    step();
    check("disabled_no_strobe", {15'd0, strobe4}, 16'd0);
    load_en = 1'b1;
    step();
    check("reenable_no_strobe", {15'd0, strobe4}, 16'd0);
    step();
    valid = 1'b0;
    step();
    step();
    press(4'd4, 1'b0);
    check("load_en_digits", digits4, 16'h0004);
    check("load_en_count", {13'd0, count4}, 16'd1);

    // Clear wins over a simultaneous accept; non-BCD codes are rejected.
    press(4'd8, 1'b1);
    check("clear_prio_digits", digits4, 16'h0);
    check("clear_prio_count", {13'd0, count4}, 16'd0);
    press(4'hA, 1'b0);
    check("reject_digits", digits4, 16'h0);
    check("reject_count", {13'd0, count4}, 16'd0);

    // Display scan on 12:30 for both prescaler settings.
    press(4'd1, 1'b0);
    press(4'd2, 1'b0);
    press(4'd3, 1'b0);
    press(4'd0, 1'b0);
    check("scan_digits_div1", digits1, 16'h1230);
    scan_check(4, 1'b0);
    scan_check(1, 1'b1);

    // Reset mid-entry with a key held across reset release.
    do_clear();
    press(4'd6, 1'b0);
    press(4'd2, 1'b0);
    check("pre_rst_digits", digits4, 16'h0062);
    bcd_in = 4'd3;
    valid  = 1'b1;
    rst    = 1'b1;
    step();
    check_reset_state("mid_rst");
    m_digits = 16'h0003;
    m_count  = 3'd1;
    sb.push_back('{d: m_digits, c: m_count});
    pushes++;
    rst = 1'b0;
    step();
    check("post_rst_strobe", {15'd0, strobe4}, 16'd1);
    check("post_rst_digits", digits4, 16'h0003);
    check("post_rst_count", {13'd0, count4}, 16'd1);
    step();
    valid = 1'b0;
    step();
    step();

    // Every expected digit must have been matched by exactly one strobe.
    check("strobe_total", strobes_seen[15:0], pushes[15:0]);
    check("sb_empty", sb.size() == 0 ? 16'd1 : 16'd0, 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
